// File: rtl/systolic_array_nxn_if.sv
// Operand/result bundle for systolic_array_nxn.
//   start/k_len        : job launch and reduction depth K
//   in_valid/in_ready  : operand beat handshake carrying a_vec (column k of A)
//                        and b_vec (row k of B)
//   out_valid/out_ready: result row handshake carrying out_row/out_data
//   busy/done          : job status and end-of-job pulse
// master = operand/result client, slave = the array.
interface systolic_array_nxn_if #(
  parameter int N         = 2,
  parameter int WIDTH     = 8,
  parameter int MAX_K     = 255,
  parameter int ACC_WIDTH = 24
);
  localparam int KW = $clog2(MAX_K + 1);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic                   start;
  logic [KW-1:0]          k_len;
  logic                   in_valid;
  logic                   in_ready;
  logic [N*WIDTH-1:0]     a_vec;
  logic [N*WIDTH-1:0]     b_vec;
  logic                   out_valid;
  logic                   out_ready;
  logic [RW-1:0]          out_row;
  logic [N*ACC_WIDTH-1:0] out_data;
  logic                   busy;
  logic                   done;

  modport master (
    output start, k_len, in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, out_row, out_data, busy, done
  );

  modport slave (
    input  start, k_len, in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, out_row, out_data, busy, done
  );
endinterface

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary signed MAC grid computing C = A(NxK) * B(KxN).
// Operands enter through a skew stage (row i of A delayed i cycles, column j
// of B delayed j cycles), ripple right/down through the PEs, and accumulate
// in place. A LOAD/DRAIN/OUTPUT FSM sequences the job and streams C out one
// row per handshake.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : systolic_array_nxn_if.slave (start/k_len, operand and result
//          handshakes, busy/done)

// One processing element: registers the operands it forwards and adds the
// sign-extended product of its current inputs into its accumulator.
module systolic_pe #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  output logic [ACC_WIDTH-1:0] acc_o
);
  logic signed [2*WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]      prod_ext;
  logic [WIDTH-1:0]          a_q, b_q;
  logic [ACC_WIDTH-1:0]      acc_q;

  assign prod     = $signed(a_i) * $signed(b_i);
  assign prod_ext = ACC_WIDTH'(prod);  // prod is signed, so this sign-extends

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (clr_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_q + prod_ext;  // wraps modulo 2^ACC_WIDTH
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;
endmodule

module systolic_array_nxn #(
  parameter int N         = 2,
  parameter int WIDTH     = 8,
  parameter int MAX_K     = 255,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_array_nxn_if.slave  bus
);
  localparam int KW = $clog2(MAX_K + 1);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = $clog2(2 * N);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUTPUT} state_t;

  state_t        state_q;
  logic [KW-1:0] k_q, beat_q;
  logic [DW-1:0] drain_q;
  logic [RW-1:0] out_row_q;
  logic          in_ready_q, out_valid_q;

  logic accept, clr;
  assign accept = bus.in_valid & in_ready_q;
  assign clr    = (state_q == S_IDLE) & bus.start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      beat_q      <= '0;
      drain_q     <= '0;
      out_row_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          k_q       <= bus.k_len;
          beat_q    <= '0;
          drain_q   <= '0;
          out_row_q <= '0;
          if (bus.k_len != '0) begin
            state_q    <= S_LOAD;
            in_ready_q <= 1'b1;
          end else begin
            state_q    <= S_DRAIN;
          end
        end
        S_LOAD: if (accept) begin
          beat_q <= beat_q + KW'(1);
          // compare against K-1 so K = MAX_K never needs a wider counter
          if (beat_q == k_q - KW'(1)) begin
            state_q    <= S_DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          // 2N-1 zero cycles flush the longest skew + propagation path
          if (drain_q == DW'(2 * N - 2)) begin
            state_q     <= S_OUTPUT;
            out_valid_q <= 1'b1;
            out_row_q   <= '0;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        S_OUTPUT: if (bus.out_ready) begin
          if (out_row_q == RW'(N - 1)) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
          end else begin
            out_row_q <= out_row_q + RW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Non-accepted cycles (bubbles, drain) inject zeros, which add nothing.
  logic [N-1:0][WIDTH-1:0] inj_a, inj_b;
  assign inj_a = accept ? bus.a_vec : '0;
  assign inj_b = accept ? bus.b_vec : '0;

  // a_h[i][j]: A operand entering PE(i,j) from the left; b_v[i][j]: B operand
  // entering PE(i,j) from above. The extra column/row is the array edge.
  logic [N-1:0][N:0][WIDTH-1:0]         a_h;
  logic [N:0][N-1:0][WIDTH-1:0]         b_v;
  logic [N-1:0][N-1:0][ACC_WIDTH-1:0]   acc;

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_h[0][0] = inj_a[0];
      assign b_v[0][0] = inj_b[0];
    end else begin : g_delay
      logic [i-1:0][WIDTH-1:0] sa_q, sb_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sa_q <= '0;
          sb_q <= '0;
        end else if (clr) begin
          sa_q <= '0;
          sb_q <= '0;
        end else begin
          sa_q[0] <= inj_a[i];
          sb_q[0] <= inj_b[i];
          for (int d = 1; d < i; d++) begin
            sa_q[d] <= sa_q[d-1];
            sb_q[d] <= sb_q[d-1];
          end
        end
      end
      assign a_h[i][0] = sa_q[i-1];
      assign b_v[0][i] = sb_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .a_i   (a_h[i][j]),
        .b_i   (b_v[i][j]),
        .a_o   (a_h[i][j+1]),
        .b_o   (b_v[i+1][j]),
        .acc_o (acc[i][j])
      );
    end
  end

  // Operands falling off the right/bottom edge go nowhere.
  logic unused_edge;
  always_comb begin
    unused_edge = ^b_v[N];
    for (int i = 0; i < N; i++) unused_edge = unused_edge ^ (^a_h[i][N]);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_data  = out_valid_q ? acc[out_row_q] : '0;
  assign bus.busy      = (state_q != S_IDLE);
  // Combinational so that a new start is taken in the very next cycle.
  assign bus.done      = (state_q == S_OUTPUT) & bus.out_ready &
                         (out_row_q == RW'(N - 1));
endmodule

// File: tb/tb_systolic_array_nxn.sv
module tb_systolic_array_nxn;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_array_nxn_if #(.N(2), .WIDTH(8), .MAX_K(255), .ACC_WIDTH(24)) u2 ();
  systolic_array_nxn_if #(.N(4), .WIDTH(8), .MAX_K(255), .ACC_WIDTH(24)) u4 ();

  systolic_array_nxn #(.N(2), .WIDTH(8), .MAX_K(255), .ACC_WIDTH(24)) dut2 (
    .clk(clk), .rst(rst), .bus(u2));
  systolic_array_nxn #(.N(4), .WIDTH(8), .MAX_K(255), .ACC_WIDTH(24)) dut4 (
    .clk(clk), .rst(rst), .bus(u4));

  int checks = 0;
  int errors = 0;
  logic [15:0] a2 [0:3];
  logic [15:0] b2 [0:3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One N=2 job: k beats with `gap` idle cycles between beats, `bp` cycles of
  // backpressure on row 0, optional stray start pulses in LOAD and OUTPUT.
  task automatic job2(input string tag, input int k, input int gap, input int bp,
                      input bit glitch, input int e00, input int e01,
                      input int e10, input int e11);
    int n;
    int ex [0:1][0:1];
    ex[0][0] = e00; ex[0][1] = e01; ex[1][0] = e10; ex[1][1] = e11;
    u2.start = 1'b1; u2.k_len = 8'(k);
    step();
    u2.start = 1'b0;
    chk({tag, ".busy"}, 32'(u2.busy), 32'd1);
    chk({tag, ".in_ready"}, 32'(u2.in_ready), 32'(k > 0));
    for (int b = 0; b < k; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          u2.in_valid = 1'b0;
          u2.start = glitch && (g == 0); u2.k_len = 8'd0;
          step();
          u2.start = 1'b0;
          chk($sformatf("%s.bubble_ready%0d", tag, g), 32'(u2.in_ready), 32'd1);
        end
      end
      u2.in_valid = 1'b1; u2.a_vec = a2[b]; u2.b_vec = b2[b];
      step();
    end
    u2.in_valid = 1'b0; u2.a_vec = '0; u2.b_vec = '0;
    chk({tag, ".ready_off"}, 32'(u2.in_ready), 32'd0);
    n = 0;
    while (!u2.out_valid && n < 100) begin step(); n++; end
    chk({tag, ".drain_cycles"}, 32'(n), 32'd3);
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin
        for (int c = 0; c < bp; c++) begin
          u2.out_ready = 1'b0;
          u2.start = glitch && (c == 1); u2.k_len = 8'd0;
          #1;
          chk($sformatf("%s.bp_row%0d", tag, c), 32'(u2.out_row), 32'd0);
          chk($sformatf("%s.bp_d0_%0d", tag, c), 32'(u2.out_data[23:0]), 32'(ex[0][0]));
          chk($sformatf("%s.bp_d1_%0d", tag, c), 32'(u2.out_data[47:24]), 32'(ex[0][1]));
          chk($sformatf("%s.bp_done%0d", tag, c), 32'(u2.done), 32'd0);
          step();
          u2.start = 1'b0;
          chk($sformatf("%s.bp_valid%0d", tag, c), 32'(u2.out_valid), 32'd1);
        end
      end
      chk($sformatf("%s.valid%0d", tag, r), 32'(u2.out_valid), 32'd1);
      chk($sformatf("%s.row%0d", tag, r), 32'(u2.out_row), 32'(r));
      for (int j = 0; j < 2; j++)
        chk($sformatf("%s.c%0d%0d", tag, r, j), 32'(u2.out_data[j*24 +: 24]),
            32'(ex[r][j]));
      u2.out_ready = 1'b1;
      #1;
      chk($sformatf("%s.done%0d", tag, r), 32'(u2.done), 32'(r == 1));
      step();
      u2.out_ready = 1'b0;
    end
    chk({tag, ".valid_end"}, 32'(u2.out_valid), 32'd0);
    chk({tag, ".busy_end"}, 32'(u2.busy), 32'd0);
  endtask

  task automatic set_t1_operands();
    // a_vec = {A[1][k], A[0][k]}, b_vec = {B[k][1], B[k][0]}
    a2[0] = 16'h0301; b2[0] = 16'h0605;
    a2[1] = 16'h0402; b2[1] = 16'h0807;
  endtask

  initial begin
    int n;
    u2.start = 0; u2.k_len = 0; u2.in_valid = 0; u2.a_vec = 0; u2.b_vec = 0; u2.out_ready = 0;
    u4.start = 0; u4.k_len = 0; u4.in_valid = 0; u4.a_vec = 0; u4.b_vec = 0; u4.out_ready = 0;
    #12;
    chk("rst.in_ready", 32'(u2.in_ready), 32'd0);
    chk("rst.out_valid", 32'(u2.out_valid), 32'd0);
    chk("rst.out_row", 32'(u2.out_row), 32'd0);
    chk("rst.out_data", 32'(u2.out_data), 32'd0);
    chk("rst.busy", 32'(u2.busy), 32'd0);
    chk("rst.done", 32'(u2.done), 32'd0);
    step();
    rst = 1'b1;
    step();

    set_t1_operands();
    job2("t1_basic", 2, 0, 0, 1'b0, 19, 22, 43, 50);
    job2("t2_bubbles", 2, 3, 0, 1'b0, 19, 22, 43, 50);
    for (int b = 0; b < 3; b++) begin a2[b] = 16'h8080; b2[b] = 16'h8080; end
    job2("t3_neg", 3, 0, 0, 1'b0, 49152, 49152, 49152, 49152);
    job2("t4_k0", 0, 0, 0, 1'b0, 0, 0, 0, 0);
    set_t1_operands();
    job2("t5_bp", 2, 0, 4, 1'b0, 19, 22, 43, 50);
    job2("t6_glitch", 2, 2, 3, 1'b1, 19, 22, 43, 50);

    // Reset in the middle of LOAD, then a fresh job.
    u2.start = 1'b1; u2.k_len = 8'd2;
    step();
    u2.start = 1'b0;
    u2.in_valid = 1'b1; u2.a_vec = a2[0]; u2.b_vec = b2[0];
    step();
    u2.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst.in_ready", 32'(u2.in_ready), 32'd0);
    chk("mid_rst.busy", 32'(u2.busy), 32'd0);
    chk("mid_rst.out_valid", 32'(u2.out_valid), 32'd0);
    chk("mid_rst.out_row", 32'(u2.out_row), 32'd0);
    chk("mid_rst.out_data", 32'(u2.out_data), 32'd0);
    chk("mid_rst.done", 32'(u2.done), 32'd0);
    step();
    rst = 1'b1;
    step();
    job2("t7_after_rst", 2, 0, 0, 1'b0, 19, 22, 43, 50);

    // N=4, A = identity, B[k][j] = 4k+j+1, so C = B.
    u4.start = 1'b1; u4.k_len = 8'd4;
    step();
    u4.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      u4.in_valid = 1'b1;
      u4.a_vec = 32'd1 << (8 * k);
      u4.b_vec = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
      step();
    end
    u4.in_valid = 1'b0;
    n = 0;
    while (!u4.out_valid && n < 100) begin step(); n++; end
    chk("n4.drain_cycles", 32'(n), 32'd7);
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("n4.row%0d", r), 32'(u4.out_row), 32'(r));
      for (int j = 0; j < 4; j++)
        chk($sformatf("n4.c%0d%0d", r, j), 32'(u4.out_data[j*24 +: 24]), 32'(4*r + j + 1));
      u4.out_ready = 1'b1;
      #1;
      chk($sformatf("n4.done%0d", r), 32'(u4.done), 32'(r == 3));
      step();
      u4.out_ready = 1'b0;
    end
    chk("n4.busy_end", 32'(u4.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
